// File: rtl/apb_fifo_v2.sv
// APB3 slave wrapping a WIDTH x DEPTH FIFO with CTRL/THRESH/STATUS/DATA registers.
// Define APB_FIFO_V2_IRQ_EN to add the IRQ_EN register at 0x10 and drive irq.
module apb_fifo_v2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_THRESH = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_DATA   = 8'h0C;
  localparam logic [7:0] A_IRQEN  = 8'h10;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_en, r_dof, r_ovf, r_udf;
  logic [7:0]       r_af_th, r_ae_th;

  logic        w_acc, w_wr, w_rd, w_data;
  logic        w_empty, w_full, w_afull, w_aempty;
  logic        w_push, w_pop, w_ovf_set, w_udf_set, w_clr;
  logic [7:0]  w_cnt8;
  logic [31:0] w_head;
  logic        w_unused;

  assign PREADY   = 1'b1;
  assign w_acc    = PSEL & PENABLE;
  assign w_wr     = w_acc & PWRITE;
  assign w_rd     = w_acc & ~PWRITE;
  assign w_data   = (PADDR == A_DATA) & r_en;
  assign w_cnt8   = 8'(r_count);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_afull  = (w_cnt8 >= r_af_th);
  assign w_aempty = (w_cnt8 <= r_ae_th);
  assign w_push    = w_wr & w_data & ~w_full;
  assign w_ovf_set = w_wr & w_data & w_full;
  assign w_pop     = w_rd & w_data & ~w_empty;
  assign w_udf_set = w_rd & w_data & w_empty;
  assign w_clr     = w_wr & (PADDR == A_CTRL) & PWDATA[1];
  assign w_unused  = ^PWDATA;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en    <= 1'b0;
      r_dof   <= 1'b0;
      r_af_th <= 8'(DEPTH - 1);
      r_ae_th <= 8'd1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr && PADDR == A_CTRL) begin
        r_en  <= PWDATA[0];
        r_dof <= PWDATA[2];
      end
      if (w_wr && PADDR == A_THRESH) begin
        r_af_th <= PWDATA[7:0];
        r_ae_th <= PWDATA[15:8];
      end
      if (w_clr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_udf   <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push)     r_count <= r_count + 1'b1;
        else if (w_pop) r_count <= r_count - 1'b1;
        if (w_ovf_set) r_ovf <= 1'b1;
        else if (w_wr && PADDR == A_STATUS && PWDATA[4]) r_ovf <= 1'b0;
        if (w_udf_set) r_udf <= 1'b1;
        else if (w_wr && PADDR == A_STATUS && PWDATA[5]) r_udf <= 1'b0;
      end
    end
  end

  // Storage is deliberately left unreset; count/pointers define validity.
  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wptr] <= PWDATA[WIDTH-1:0];
  end

  always_comb begin
    w_head = '0;
    w_head[WIDTH-1:0] = r_mem[r_rptr];
  end

`ifdef APB_FIFO_V2_IRQ_EN
  logic [3:0] r_irq_en;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                     r_irq_en <= '0;
    else if (w_wr && PADDR == A_IRQEN) r_irq_en <= PWDATA[3:0];
  end
  assign irq = |(r_irq_en & {r_udf, r_ovf, w_aempty, w_afull});
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (w_acc) begin
      case (PADDR)
        A_CTRL:   if (!PWRITE) PRDATA = {29'd0, r_dof, 1'b0, r_en};
        A_THRESH: if (!PWRITE) PRDATA = {16'd0, r_ae_th, r_af_th};
        A_STATUS: if (!PWRITE) PRDATA = {16'd0, w_cnt8, 2'b00, r_udf, r_ovf,
                                         w_aempty, w_afull, w_full, w_empty};
        A_DATA: begin
          if (r_en) begin
            if (PWRITE)       PSLVERR = w_full & ~r_dof;
            else if (w_empty) PSLVERR = 1'b1;
            else              PRDATA  = w_head;
          end
        end
`ifdef APB_FIFO_V2_IRQ_EN
        A_IRQEN:  if (!PWRITE) PRDATA = {28'd0, r_irq_en};
`endif
        default:  PSLVERR = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_fifo_v2.sv
// Randomized self-checking bench for apb_fifo_v2 against a queue-based register model.
module tb_apb_fifo_v2;
  logic        PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [7:0]  PADDR = 0;
  logic [31:0] PWDATA = 0, PRDATA;
  logic        PREADY, PSLVERR, irq;
  int errs = 0, checks = 0;

  apb_fifo_v2 #(.WIDTH(8), .DEPTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq(irq));

  always #5 PCLK = ~PCLK;

  // reference model
  logic [7:0] q[$];
  bit         m_en, m_dof, m_ovf, m_udf;
  logic [7:0] m_af, m_ae;
  logic [3:0] m_ie;

  task automatic mdl_reset();
    q.delete(); m_en = 0; m_dof = 0; m_ovf = 0; m_udf = 0;
    m_af = 8'd15; m_ae = 8'd1; m_ie = 0;
  endtask

  function automatic logic [31:0] mdl_status();
    int c = q.size();
    logic [31:0] s = 0;
    s[0] = (c == 0); s[1] = (c == 16); s[2] = (c >= m_af); s[3] = (c <= m_ae);
    s[4] = m_ovf; s[5] = m_udf; s[15:8] = c[7:0];
    return s;
  endfunction

  function automatic logic mdl_irq();
`ifdef APB_FIFO_V2_IRQ_EN
    int c = q.size();
    return (m_ie[0] && c >= m_af) || (m_ie[1] && c <= m_ae) || (m_ie[2] && m_ovf) || (m_ie[3] && m_udf);
`else
    return 1'b0;
`endif
  endfunction

  task automatic mdl_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    err = 0;
    case (a)
      8'h00: begin
        m_en = d[0]; m_dof = d[2];
        if (d[1]) begin q.delete(); m_ovf = 0; m_udf = 0; end
      end
      8'h04: begin m_af = d[7:0]; m_ae = d[15:8]; end
      8'h08: begin if (d[4]) m_ovf = 0; if (d[5]) m_udf = 0; end
      8'h0C: if (m_en) begin
        if (q.size() == 16) begin m_ovf = 1; err = !m_dof; end
        else q.push_back(d[7:0]);
      end
`ifdef APB_FIFO_V2_IRQ_EN
      8'h10: m_ie = d[3:0];
`endif
      default: err = 1;
    endcase
  endtask

  task automatic mdl_rd(input logic [7:0] a, output logic [31:0] data, output logic err);
    err = 0; data = 0;
    case (a)
      8'h00: data = {29'd0, m_dof, 1'b0, m_en};
      8'h04: data = {16'd0, m_ae, m_af};
      8'h08: data = mdl_status();
      8'h0C: if (m_en) begin
        if (q.size() == 0) begin m_udf = 1; err = 1; end
        else data = {24'd0, q.pop_front()};
      end
`ifdef APB_FIFO_V2_IRQ_EN
      8'h10: data = {28'd0, m_ie};
`endif
      default: err = 1;
    endcase
  endtask

  task automatic bus(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1;
    #3 rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  // one transfer on the DUT and the same transfer on the model
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err,
                      output logic [31:0] erd, output logic eerr);
    bus(wr, a, d, rd, err);
    erd = 0;
    if (wr) mdl_wr(a, d, eerr); else mdl_rd(a, erd, eerr);
  endtask

  logic [31:0] rd, erd;
  logic        er, eer;

  task automatic test_reset();
    PRESETn = 0; #2;
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b want 0", irq); end
    #20 PRESETn = 1; mdl_reset();
    checks++; if ({PRDATA, PSLVERR, PREADY} !== {32'd0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL idle_outputs: got %h/%b/%b want 0/0/1", PRDATA, PSLVERR, PREADY); end
    for (int i = 0; i < 3; i++) begin
      xfer(0, 8'(4 * i), 0, rd, er, erd, eer);
      checks++; if ({rd, er} !== {erd, eer}) begin
        errs++; $display("FAIL reset_reg%0d: got %h/%b want %h/%b", i, rd, er, erd, eer); end
    end
  endtask

  task automatic test_fill_drain();
    xfer(1, 8'h00, 32'h1, rd, er, erd, eer);
    for (int i = 1; i <= 16; i++) begin
      xfer(1, 8'h0C, i, rd, er, erd, eer);
      checks++; if (er !== eer) begin errs++; $display("FAIL push%0d_err: got %b want %b", i, er, eer); end
    end
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer} || rd[15:8] !== 8'd16 || rd[1] !== 1'b1) begin
      errs++; $display("FAIL full_status: got %h want %h", rd, erd); end
    for (int i = 1; i <= 16; i++) begin
      xfer(0, 8'h0C, 0, rd, er, erd, eer);
      checks++; if ({rd, er} !== {erd, eer}) begin
        errs++; $display("FAIL pop%0d: got %h/%b want %h/%b", i, rd, er, erd, eer); end
    end
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL empty_status: got %h want %h", rd, erd); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) xfer(1, 8'h0C, 8'h30 + i, rd, er, erd, eer);
    xfer(1, 8'h0C, 32'hAA, rd, er, erd, eer);
    checks++; if (er !== eer) begin errs++; $display("FAIL ovf_err_nodrop: got %b want %b", er, eer); end
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL ovf_status: got %h want %h", rd, erd); end
    xfer(1, 8'h00, 32'h5, rd, er, erd, eer);
    xfer(1, 8'h0C, 32'hAA, rd, er, erd, eer);
    checks++; if (er !== eer) begin errs++; $display("FAIL ovf_err_drop: got %b want %b", er, eer); end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 8'h0C, 0, rd, er, erd, eer);
      checks++; if ({rd, er} !== {erd, eer}) begin
        errs++; $display("FAIL ovf_drain%0d: got %h want %h", i, rd, erd); end
    end
    xfer(1, 8'h08, 32'h10, rd, er, erd, eer);
  endtask

  task automatic test_underflow();
    xfer(0, 8'h0C, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL udf_pop: got %h/%b want %h/%b", rd, er, erd, eer); end
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if (rd !== erd) begin errs++; $display("FAIL udf_status: got %h want %h", rd, erd); end
    xfer(1, 8'h08, 32'h20, rd, er, erd, eer);
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if (rd !== erd) begin errs++; $display("FAIL udf_w1c: got %h want %h", rd, erd); end
  endtask

  task automatic test_thresh_wrap();
    xfer(1, 8'h04, 32'h0204, rd, er, erd, eer);
    for (int i = 0; i < 6; i++) begin
      xfer(0, 8'h08, 0, rd, er, erd, eer);
      checks++; if (rd !== erd) begin errs++; $display("FAIL thresh_cnt%0d: got %h want %h", i, rd, erd); end
      xfer(1, 8'h0C, $urandom, rd, er, erd, eer);
    end
    for (int i = 0; i < 40; i++) begin
      xfer(1, 8'h0C, $urandom, rd, er, erd, eer);
      xfer(0, 8'h0C, 0, rd, er, erd, eer);
      checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL wrap%0d: got %h want %h", i, rd, erd); end
    end
  endtask

  task automatic test_disabled_setup();
    xfer(1, 8'h00, 32'h0, rd, er, erd, eer);
    xfer(1, 8'h0C, 32'h77, rd, er, erd, eer);
    checks++; if (er !== eer) begin errs++; $display("FAIL dis_push: got %b want %b", er, eer); end
    xfer(0, 8'h0C, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL dis_pop: got %h/%b want %h/%b", rd, er, erd, eer); end
    xfer(1, 8'h00, 32'h1, rd, er, erd, eer);
    // setup phase only: a DATA read must not pop
    @(posedge PCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h0C;
    @(posedge PCLK); @(posedge PCLK); #1;
    checks++; if ({PRDATA, PSLVERR} !== 33'd0) begin errs++; $display("FAIL setup_out: got %h/%b want 0/0", PRDATA, PSLVERR); end
    PSEL = 0;
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if (rd !== erd) begin errs++; $display("FAIL setup_nopop: got %h want %h", rd, erd); end
    xfer(1, 8'h14, 32'hFFFF, rd, er, erd, eer);
    checks++; if (er !== eer) begin errs++; $display("FAIL unmapped_wr: got %b want %b", er, eer); end
    xfer(0, 8'h20, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL unmapped_rd: got %h/%b want %h/%b", rd, er, erd, eer); end
  endtask

  task automatic test_irq();
    xfer(0, 8'h10, 0, rd, er, erd, eer);
    checks++; if ({rd, er} !== {erd, eer}) begin errs++; $display("FAIL irqen_rd: got %h/%b want %h/%b", rd, er, erd, eer); end
`ifdef APB_FIFO_V2_IRQ_EN
    xfer(1, 8'h00, 32'h3, rd, er, erd, eer);
    xfer(1, 8'h10, 32'h4, rd, er, erd, eer);
    for (int i = 0; i < 17; i++) xfer(1, 8'h0C, i, rd, er, erd, eer);
    checks++; if (irq !== mdl_irq() || irq !== 1'b1) begin errs++; $display("FAIL irq_ovf: got %b want 1", irq); end
    xfer(1, 8'h08, 32'h10, rd, er, erd, eer);
    checks++; if (irq !== mdl_irq()) begin errs++; $display("FAIL irq_w1c: got %b want %b", irq, mdl_irq()); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      bit wr = ($urandom_range(0, 99) < ((i < 200) ? 65 : 35));
      logic [7:0] a;
      logic [31:0] d = $urandom;
      if (r < 5) a = 8'h0C;
      else if (r == 5) begin
        a = 8'h00; d[0] = ($urandom_range(0, 3) != 0); d[1] = ($urandom_range(0, 7) == 0);
      end else if (r == 6) begin a = 8'h04; d[7:0] = 8'($urandom_range(0, 17)); d[15:8] = 8'($urandom_range(0, 17)); end
      else if (r == 7) a = 8'h08;
      else if (r == 8) a = 8'h10;
      else a = 8'h14 + 8'(4 * $urandom_range(0, 40));
      xfer(wr, a, d, rd, er, erd, eer);
      checks++; if ((wr && er !== eer) || (!wr && {rd, er} !== {erd, eer}) || irq !== mdl_irq()) begin
        errs++; $display("FAIL rand%0d a=%h wr=%b: got %h/%b/%b want %h/%b/%b", i, a, wr, rd, er, irq, erd, eer, mdl_irq());
      end
    end
  endtask

  task automatic test_clr_reset();
    xfer(1, 8'h00, 32'h3, rd, er, erd, eer);
    for (int i = 0; i < 5; i++) xfer(1, 8'h0C, 8'h50 + i, rd, er, erd, eer);
    xfer(1, 8'h00, 32'h3, rd, er, erd, eer);
    xfer(0, 8'h08, 0, rd, er, erd, eer);
    checks++; if (rd !== erd || rd[15:8] !== 8'd0 || rd[0] !== 1'b1) begin errs++; $display("FAIL clr_status: got %h want %h", rd, erd); end
    xfer(0, 8'h00, 0, rd, er, erd, eer);
    checks++; if (rd !== erd) begin errs++; $display("FAIL clr_ctrl: got %h want %h", rd, erd); end
    xfer(1, 8'h0C, 8'h99, rd, er, erd, eer);
    @(posedge PCLK); #1 PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h0C; PWDATA = 32'h66;
    @(posedge PCLK); #1 PENABLE = 1;
    #2 PRESETn = 0; #1 mdl_reset();
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL midrst_irq: got %b want 0", irq); end
    PSEL = 0; PENABLE = 0;
    @(posedge PCLK); #1 PRESETn = 1;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 8'(4 * i), 0, rd, er, erd, eer);
      checks++; if ({rd, er} !== {erd, eer}) begin
        errs++; $display("FAIL midrst_reg%0d: got %h/%b want %h/%b", i, rd, er, erd, eer); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_thresh_wrap();
    test_disabled_setup();
    test_irq();
    test_random();
    test_clr_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/apb_fifo_v2.md
APB_FIFO_V2 -- requirements
Module: apb_fifo_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits stored per entry (1..32).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of 2, 2..128).
REQ-003 SHALL have port PCLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB3 control.
REQ-006 SHALL have ports PADDR  input  8, and PWDATA  input  32  (APB3 address and write data).
REQ-007 SHALL have ports PRDATA  output  32, PREADY  output  1, and PSLVERR  output  1  (APB3 responses).
REQ-008 SHALL have port irq  output  1  level interrupt.

Function
REQ-009 SHALL tie PREADY to 1; every transfer completes in its access phase (PSEL&PENABLE).
REQ-010 SHALL commit register writes, pushes, pops and W1C on the access-phase edge only; setup phase has no effect.
REQ-011 SHALL map CTRL 0x00: [0] en, [1] clr (reads 0), [2] drop_on_full.
REQ-012 SHALL map THRESH 0x04: [7:0] af_th, [15:8] ae_th.
REQ-013 SHALL map STATUS 0x08: [0] empty, [1] full, [2] almost_full, [3] almost_empty, [4] overflow, [5] underflow, [15:8] count; writing 1 to [4]/[5] clears that bit; other writes are ignored.
REQ-014 SHALL map DATA 0x0C: a write pushes PWDATA[WIDTH-1:0]; a read pops and returns the head entry zero-extended on PRDATA in the same access phase.
REQ-015 SHALL hold count in $clog2(DEPTH)+1 bits and reach exactly DEPTH when full; pointers wrap modulo DEPTH.
REQ-016 SHALL derive flags combinationally from current count: empty=(count==0), full=(count==DEPTH), almost_full=(count>=af_th), almost_empty=(count<=ae_th).
REQ-017 SHALL, on a push while full: discard the data, set overflow, and assert PSLVERR=0 if drop_on_full=1 or PSLVERR=1 otherwise.
REQ-018 SHALL, on a pop while empty: return PRDATA=0, set underflow, assert PSLVERR=1, and leave pointers unchanged.
REQ-019 SHALL ignore DATA accesses while en=0 (no pointer/count/flag change, PRDATA=0, PSLVERR=0).
REQ-020 SHALL, on a CTRL write with clr=1, zero the pointers, count, overflow and underflow at that edge, while en and drop_on_full take the written values.
REQ-021 SHALL respond to an unmapped address with PSLVERR=1 and PRDATA=0; such writes change no state.
REQ-022 SHALL drive PRDATA=0 and PSLVERR=0 whenever no access phase is active.
REQ-023 SHALL keep overflow/underflow sticky until a W1C or clr.

Reset
REQ-024 SHALL, with PRESETn low, immediately force: en=0, drop_on_full=0, af_th=DEPTH-1, ae_th=1, pointers=0, count=0, overflow=0, underflow=0, irq_en=0, irq=0.
REQ-025 SHALL leave FIFO storage unreset; a reset mid-operation discards all contents.

Configuration
REQ-026 SHALL compile in interrupt support only when APB_FIFO_V2_IRQ_EN is defined: IRQ_EN register at 0x10 ([0] almost_full, [1] almost_empty, [2] overflow, [3] underflow, reset 0), and irq = OR of each enabled source.
REQ-027 SHALL, without APB_FIFO_V2_IRQ_EN, tie irq to 0 and treat 0x10 as unmapped per REQ-021.

Verification
REQ-028 SHALL cover: reset, en=1, push 16 values 0x01..0x10 -> full=1, count=16; 16 pops return 0x01..0x10 in order; empty=1.
REQ-029 SHALL cover: full FIFO, drop_on_full=0, push 0xAA -> PSLVERR=1, overflow=1, count=16; same push with drop_on_full=1 -> PSLVERR=0.
REQ-030 SHALL cover: empty FIFO, pop -> PRDATA=0, PSLVERR=1, underflow=1; write STATUS 0x20 -> underflow=0.
REQ-031 SHALL cover: THRESH=0x0204 -> almost_empty at count<=2, almost_full at count>=4; then 40 push/pop pairs to exercise pointer wrap with data intact.
REQ-032 SHALL cover: 5 entries, CTRL write 0x3 -> count=0, empty=1, en=1; then PRESETn pulsed low mid-transfer -> all REQ-024 values.
REQ-033 SHALL cover, with APB_FIFO_V2_IRQ_EN defined: IRQ_EN=0x4, overflowing push -> irq=1; W1C overflow -> irq=0; without the macro, read 0x10 -> PSLVERR=1.
